// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_pkg
//  Purpose  : Shared fetch-stage types and instruction-register control codes.
//  Revision : 1.0  initial release
// ============================================================================
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DONE  = 2'd2,
        FAULT = 2'd3
    } fetch_state_t;

    localparam logic [1:0]  IR_CLEAR    = 2'b10;
    localparam logic [1:0]  IR_LOAD     = 2'b01;
    localparam logic [1:0]  IR_HOLD     = 2'b00;
    localparam logic [31:0] INSTR_BYTES = 32'd4;

    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit_if
//  Purpose  : Instruction-memory read handshake between fetch stage and memory.
//  Revision : 1.0  initial release
// ============================================================================
interface fetch_unit_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (output mem_req, output mem_addr, input mem_ready, input mem_rdata);
    modport slave  (input mem_req, input mem_addr, output mem_ready, output mem_rdata);
endinterface
`default_nettype wire

// File: rtl/fetch_unit_program_counter.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit_program_counter
//  Purpose  : PC, previous-PC and deferred-redirect registers for fetch_unit.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_unit_program_counter
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        advance,
    input  wire logic        defer,
    input  wire logic        redirect,
    input  wire logic [31:0] target,
    input  wire logic        set,
    input  wire logic [31:0] set_val,
    output logic      [31:0] pc,
    output logic      [31:0] pc_old
);

    logic [31:0] r_pc;
    logic [31:0] r_pc_old;
    logic [31:0] r_pend_pc;
    logic        r_pending;

    // Advance wins over everything; a same-cycle redirect beats a stale pending target.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc      <= RESET_PC;
            r_pc_old  <= RESET_PC;
            r_pend_pc <= RESET_PC;
            r_pending <= 1'b0;
        end else if (advance) begin
            r_pc_old  <= r_pc;
            r_pending <= 1'b0;
            if (redirect)
                r_pc <= target;
            else if (r_pending)
                r_pc <= r_pend_pc;
            else
                r_pc <= r_pc + INSTR_BYTES;
        end else if (defer) begin
            r_pend_pc <= target;
            r_pending <= 1'b1;
        end else if (set) begin
            r_pc <= set_val;
        end
    end

    assign pc     = r_pc;
    assign pc_old = r_pc_old;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Multicycle instruction fetch: PC ownership, memory handshake, IR control.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  wire logic         clk,
    input  wire logic         reset,
    input  wire logic         fetch_start,
    input  wire logic         pc_load,
    input  wire logic [31:0]  pc_next,
    fetch_unit_if.master      mem,
    output logic      [1:0]   ir_control,
    output logic      [31:0]  instr_data,
    output logic      [31:0]  pc,
    output logic      [31:0]  pc_old,
    output logic              fetch_done,
    output logic              busy,
    output logic              fault
);

    fetch_state_t r_state;
    logic         r_mem_req;
    logic         r_fetch_done;
    logic         r_busy;
    logic         r_fault;
    logic         r_fault_entry;

    logic [31:0]  w_pc;
    logic [31:0]  w_fa;
    logic         w_advance;
    logic         w_defer;
    logic         w_set;

    assign w_fa      = pc_load ? pc_next : w_pc;
    assign w_advance = (r_state == REQ) && mem.mem_ready;
    assign w_defer   = (r_state == REQ) && pc_load;
    // In IDLE the fetch address is always written back; elsewhere only a redirect moves the PC.
    assign w_set     = ((r_state == IDLE) && (fetch_start || pc_load)) ||
                       (((r_state == DONE) || (r_state == FAULT)) && pc_load);

    fetch_unit_program_counter #(
        .RESET_PC (RESET_PC)
    ) u_program_counter (
        .clk      (clk),
        .reset    (reset),
        .advance  (w_advance),
        .defer    (w_defer),
        .redirect (pc_load),
        .target   (pc_next),
        .set      (w_set),
        .set_val  (w_fa),
        .pc       (w_pc),
        .pc_old   (pc_old)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_mem_req     <= 1'b0;
            r_fetch_done  <= 1'b0;
            r_busy        <= 1'b0;
            r_fault       <= 1'b0;
            r_fault_entry <= 1'b0;
        end else begin
            r_fault_entry <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (fetch_start) begin
                        if (is_word_aligned(w_fa)) begin
                            r_state   <= REQ;
                            r_mem_req <= 1'b1;
                            r_busy    <= 1'b1;
                        end else begin
                            r_state       <= FAULT;
                            r_fault       <= 1'b1;
                            r_fault_entry <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (mem.mem_ready) begin
                        r_state      <= DONE;
                        r_mem_req    <= 1'b0;
                        r_fetch_done <= 1'b1;
                    end
                end
                DONE: begin
                    r_state      <= IDLE;
                    r_fetch_done <= 1'b0;
                    r_busy       <= 1'b0;
                end
                FAULT: begin
                    if (pc_load) begin
                        r_state <= IDLE;
                        r_fault <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Reset forces clear and suppresses load, so 2'b11 cannot be produced.
    assign ir_control = (reset || r_fault_entry) ? IR_CLEAR :
                        w_advance                ? IR_LOAD  : IR_HOLD;

    assign mem.mem_req  = r_mem_req;
    assign mem.mem_addr = w_pc;
    assign instr_data   = mem.mem_rdata;
    assign pc           = w_pc;
    assign fetch_done   = r_fetch_done;
    assign busy         = r_busy;
    assign fault        = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Purpose  : Scoreboard-driven self-checking bench for fetch_unit.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_unit;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_start;
    logic        pc_load;
    logic [31:0] pc_next;
    logic [1:0]  ir_control;
    logic [31:0] instr_data;
    logic [31:0] pc;
    logic [31:0] pc_old;
    logic        fetch_done;
    logic        busy;
    logic        fault;

    fetch_unit_if mem_if ();

    fetch_unit #(
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_start (fetch_start),
        .pc_load     (pc_load),
        .pc_next     (pc_next),
        .mem         (mem_if),
        .ir_control  (ir_control),
        .instr_data  (instr_data),
        .pc          (pc),
        .pc_old      (pc_old),
        .fetch_done  (fetch_done),
        .busy        (busy),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] next_pc;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // redir_cyc: wait-cycle index (0..waits) in which pc_load is raised, -1 for none.
    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] word, input int waits,
                            input int redir_cyc, input logic [31:0] redir_pc);
        exp_t e;
        e.addr    = addr;
        e.data    = word;
        e.next_pc = (redir_cyc >= 0) ? redir_pc : addr + 32'd4;
        sb.push_back(e);
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        for (int c = 0; c <= waits; c++) begin
            pc_load          = (c == redir_cyc);
            pc_next          = redir_pc;
            mem_if.mem_ready = (c == waits);
            mem_if.mem_rdata = (c == waits) ? word : ~word;
            #1;
            check("mem_req", 32'(mem_if.mem_req), 32'd1);
            check("mem_addr", mem_if.mem_addr, addr);
            if (c < waits) begin
                check("ir_hold", 32'(ir_control), 32'(IR_HOLD));
                check("done_early", 32'(fetch_done), 32'd0);
            end else begin
                e = sb.pop_front();
                check("ir_load", 32'(ir_control), 32'(IR_LOAD));
                check("instr_data", instr_data, e.data);
                check("sb_addr", mem_if.mem_addr, e.addr);
            end
            tick();
        end
        pc_load          = 1'b0;
        mem_if.mem_ready = 1'b0;
        #1;
        check("fetch_done", 32'(fetch_done), 32'd1);
        check("req_drop", 32'(mem_if.mem_req), 32'd0);
        check("busy_done", 32'(busy), 32'd1);
        check("ir_after", 32'(ir_control), 32'(IR_HOLD));
        check("pc_next", pc, e.next_pc);
        check("pc_old", pc_old, e.addr);
        tick();
        check("done_pulse", 32'(fetch_done), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        reset            = 1'b1;
        fetch_start      = 1'b0;
        pc_load          = 1'b0;
        pc_next          = 32'h0;
        mem_if.mem_ready = 1'b0;
        mem_if.mem_rdata = 32'h0;
        tick();
        #1;
        check("rst_ir_clear", 32'(ir_control), 32'(IR_CLEAR));
        check("rst_req", 32'(mem_if.mem_req), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        check("rst_pc", pc, 32'h0);
        check("rst_pc_old", pc_old, 32'h0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(fetch_done), 32'd0);
        check("rst_ir_idle", 32'(ir_control), 32'(IR_HOLD));

        // mem_ready while idle must not load the IR
        mem_if.mem_ready = 1'b1;
        #1;
        check("idle_ready_ir", 32'(ir_control), 32'(IR_HOLD));
        check("idle_ready_req", 32'(mem_if.mem_req), 32'd0);
        mem_if.mem_ready = 1'b0;
        tick();

        do_fetch(32'h0000_0000, 32'h0000_0013, 0, -1, 32'h0);
        do_fetch(32'h0000_0004, 32'hDEAD_BEEF, 3, -1, 32'h0);
        do_fetch(32'h0000_0008, 32'h1234_5678, 2, 1, 32'h0000_0100);
        do_fetch(32'h0000_0100, 32'hCAFE_F00D, 1, -1, 32'h0);
        do_fetch(32'h0000_0104, 32'h0BAD_0BAD, 2, 2, 32'h0000_0180);

        // misaligned redirect combined with fetch_start
        fetch_start = 1'b1;
        pc_load     = 1'b1;
        pc_next     = 32'h0000_0102;
        tick();
        pc_load = 1'b0;
        #1;
        check("flt_flag", 32'(fault), 32'd1);
        check("flt_ir_clear", 32'(ir_control), 32'(IR_CLEAR));
        check("flt_req", 32'(mem_if.mem_req), 32'd0);
        check("flt_pc", pc, 32'h0000_0102);
        tick();
        check("flt_ir_once", 32'(ir_control), 32'(IR_HOLD));
        check("flt_sticky", 32'(fault), 32'd1);
        tick();
        check("flt_start_ign", 32'(mem_if.mem_req), 32'd0);
        check("flt_busy", 32'(busy), 32'd0);
        fetch_start = 1'b0;
        pc_load     = 1'b1;
        pc_next     = 32'h0000_0200;
        tick();
        pc_load = 1'b0;
        check("flt_clear", 32'(fault), 32'd0);
        check("flt_pc_new", pc, 32'h0000_0200);
        do_fetch(32'h0000_0200, 32'h0000_0093, 0, -1, 32'h0);

        // PC wrap at the top of the address space
        pc_load = 1'b1;
        pc_next = 32'hFFFF_FFFC;
        tick();
        pc_load = 1'b0;
        check("wrap_set", pc, 32'hFFFF_FFFC);
        do_fetch(32'hFFFF_FFFC, 32'h5555_AAAA, 1, -1, 32'h0);

        // reset landing on the same cycle as mem_ready aborts the fetch
        pc_load = 1'b1;
        pc_next = 32'h0000_0300;
        tick();
        pc_load     = 1'b0;
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        tick();
        check("abort_req", 32'(mem_if.mem_req), 32'd1);
        check("abort_addr", mem_if.mem_addr, 32'h0000_0300);
        reset            = 1'b1;
        mem_if.mem_ready = 1'b1;
        mem_if.mem_rdata = 32'h7777_7777;
        #1;
        check("abort_ir", 32'(ir_control), 32'(IR_CLEAR));
        tick();
        reset            = 1'b0;
        mem_if.mem_ready = 1'b0;
        check("abort_req_drop", 32'(mem_if.mem_req), 32'd0);
        check("abort_pc", pc, 32'h0000_0000);
        check("abort_pc_old", pc_old, 32'h0000_0000);
        tick();
        check("abort_no_done", 32'(fetch_done), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
